// File: rtl/imem_loader.sv
// Instruction memory program loader and sequencer.
// Streams host words into imem, holds the core until the image is written.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] len_q;
  logic            xfer;
  logic            last;

  // Handshake and status decode straight from the state register.
  assign s_ready = (state == LOAD);
  assign busy    = (state != IDLE);
  assign xfer    = s_valid & s_ready;
  assign last    = (count == (len_q - ONE));

  // Session sequencer; every output except s_ready/busy is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      len_q     <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len > DEPTH) begin
              err <= 1'b1;
            end else begin
              err      <= 1'b0;
              checksum <= '0;
              count    <= '0;
              len_q    <= len;
              if (len == '0) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                core_hold <= 1'b1;
                state     <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_waddr <= count[ADDR_W-1:0];
            mem_wdata <= s_data;
            checksum  <= checksum + s_data;
            count     <= count + ONE;
            if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          // Release only after the final write has been committed.
          core_hold <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
// Expected writes are queued at drive time and popped by a write monitor.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   checksum;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  nwr    = 0;
  int  ndone  = 0;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // Write monitor: every observed write pops and checks the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) ndone++;
      if (mem_we) begin
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%08h", mem_waddr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (mem_waddr !== e.a || mem_wdata !== e.d) begin
            errors++;
            $display("FAIL write got=%0d/%08h want=%0d/%08h",
                     mem_waddr, mem_wdata, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input logic [AW:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
    #12;
    checks++;
    if ({s_ready, mem_we, mem_waddr, mem_wdata, busy, done, err, checksum} !== '0
        || core_hold !== 1'b1) begin
      errors++;
      $display("FAIL reset_values rdy=%b we=%b a=%0d d=%h hold=%b busy=%b done=%b err=%b cs=%h",
               s_ready, mem_we, mem_waddr, mem_wdata, core_hold, busy, done, err, checksum);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int w0, d0;
    w0 = nwr; d0 = ndone;
    exp_q.push_back('{8'd0, 32'h00a00093});
    exp_q.push_back('{8'd1, 32'h00100113});
    begin_session(9'd2);
    s_valid = 1'b1; s_data = 32'h00a00093; tick();
    s_data = 32'h00100113; tick();
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || core_hold !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL basic_last done=%b busy=%b hold=%b we=%b want 1111",
               done, busy, core_hold, mem_we);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || core_hold !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL basic_release done=%b busy=%b hold=%b we=%b want 0000",
               done, busy, core_hold, mem_we);
    end
    checks++;
    if (checksum !== 32'h00b001a6) begin
      errors++;
      $display("FAIL basic_checksum got=%h want=00b001a6", checksum);
    end
    tick();
    checks++;
    if (nwr - w0 != 2 || ndone - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_counts writes=%0d dones=%0d left=%0d want 2 1 0",
               nwr - w0, ndone - d0, exp_q.size());
    end
  endtask

  task automatic test_gaps();
    logic [6:0]  pat;
    logic [31:0] sum;
    int          k, w0;
    pat = 7'b1011001;
    sum = '0; k = 0; w0 = nwr;
    begin_session(9'd4);
    for (int i = 0; i < 7; i++) begin
      s_valid = pat[i];
      s_data  = 32'h1000_0000 + 32'(i * 32'h111);
      if (pat[i]) begin
        exp_q.push_back('{8'(k), s_data});
        sum = sum + s_data;
        k++;
      end
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || checksum !== sum) begin
      errors++;
      $display("FAIL gaps_done done=%b cs=%h want 1 %h", done, checksum, sum);
    end
    tick(); tick();
    checks++;
    if (nwr - w0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gaps_count writes=%0d left=%0d want 4 0", nwr - w0, exp_q.size());
    end
  endtask

  task automatic test_full();
    int w0;
    w0 = nwr;
    begin_session(9'd256);
    for (int i = 0; i < 256; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hffffffff;
      exp_q.push_back('{8'(i), 32'hffffffff});
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || checksum !== 32'hffffff00 || mem_waddr !== 8'd255) begin
      errors++;
      $display("FAIL full_last done=%b cs=%h a=%0d want 1 ffffff00 255",
               done, checksum, mem_waddr);
    end
    tick(); tick();
    checks++;
    if (nwr - w0 != 256 || exp_q.size() != 0 || core_hold !== 1'b0) begin
      errors++;
      $display("FAIL full_count writes=%0d left=%0d hold=%b want 256 0 0",
               nwr - w0, exp_q.size(), core_hold);
    end
  endtask

  task automatic test_err_zero();
    int  w0, d0;
    logic sawbusy;
    w0 = nwr; d0 = ndone; sawbusy = 1'b0;
    begin_session(9'd257);
    for (int i = 0; i < 3; i++) begin
      if (busy) sawbusy = 1'b1;
      tick();
    end
    checks++;
    if (err !== 1'b1 || sawbusy || core_hold !== 1'b0 || checksum !== 32'hffffff00) begin
      errors++;
      $display("FAIL err_reject err=%b busy=%b hold=%b cs=%h want 1 0 0 ffffff00",
               err, sawbusy, core_hold, checksum);
    end
    begin_session(9'd0);
    checks++;
    if (err !== 1'b0 || done !== 1'b1 || checksum !== 32'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_len err=%b done=%b cs=%h busy=%b want 0 1 0 1",
               err, done, checksum, busy);
    end
    tick(); tick();
    checks++;
    if (nwr != w0 || ndone - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_counts writes=%0d dones=%0d busy=%b want 0 1 0",
               nwr - w0, ndone - d0, busy);
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] sum;
    int          w0;
    sum = '0; w0 = nwr;
    begin_session(9'd3);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        start = 1'b1; len = 9'd5; s_valid = 1'b0;
        tick();
        start = 1'b0;
      end
      s_valid = 1'b1;
      s_data  = 32'h0000_0100 * 32'(i + 1) + 32'h7;
      exp_q.push_back('{8'(i), s_data});
      sum = sum + s_data;
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done got=%b want 1", done);
    end
    s_data = 32'hdeadbeef;
    tick(); tick();
    s_valid = 1'b0;
    tick();
    checks++;
    if (nwr - w0 != 3 || checksum !== sum || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_count writes=%0d cs=%h left=%0d want 3 %h 0",
               nwr - w0, checksum, exp_q.size(), sum);
    end
  endtask

  task automatic test_reset_mid();
    begin_session(9'd8);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h55 + 32'(i);
      exp_q.push_back('{8'(i), s_data});
      tick();
    end
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (core_hold !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0
        || checksum !== 32'h0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid hold=%b busy=%b we=%b cs=%h rdy=%b want 1 0 0 0 0",
               core_hold, busy, mem_we, checksum, s_ready);
    end
    @(negedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
    tick();
    exp_q.push_back('{8'd0, 32'h12345678});
    begin_session(9'd1);
    s_valid = 1'b1; s_data = 32'h12345678; tick();
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || core_hold !== 1'b1) begin
      errors++;
      $display("FAIL rst_new_done done=%b hold=%b want 1 1", done, core_hold);
    end
    tick(); tick();
    checks++;
    if (core_hold !== 1'b0 || checksum !== 32'h12345678 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_new_end hold=%b cs=%h left=%0d want 0 12345678 0",
               core_hold, checksum, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_full();
    test_err_zero();
    test_ignore_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader and sequencer for the word-addressed instruction memory. Accepts a stream of 32-bit instruction words from a host link over a valid/ready handshake and writes them to consecutive word addresses starting at 0. Holds the core off the instruction memory while a load is in progress and releases it once the last word is committed. Produces a running 32-bit additive checksum so the host can confirm the image.

## Interface
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words (256 by default)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a load session; acted on only in IDLE
- len  in  ADDR_W+1  number of words to load, sampled when start is accepted
- s_valid  in  1  host word valid
- s_data  in  32  host instruction word
- s_ready  out  1  loader can accept a word
- mem_we  out  1  write strobe to instruction memory
- mem_waddr  out  ADDR_W  word address (byte address bits [ADDR_W+1:2])
- mem_wdata  out  32  write data
- core_hold  out  1  keep core in reset/stall; core must not fetch while high
- busy  out  1  session in progress (LOAD or DONE)
- done  out  1  one-cycle pulse when a session completes
- err  out  1  sticky: last start was rejected because len > 2**ADDR_W
- checksum  out  32  sum mod 2**32 of all words accepted in current/last session

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: s_ready=0. On start=1:
  - len > 2**ADDR_W: err<=1, stay IDLE; core_hold and checksum unchanged.
  - len == 0: err<=0, checksum<=0, count<=0, go to DONE (no writes).
  - Otherwise: err<=0, checksum<=0, count<=0, core_hold<=1, go to LOAD.
- LOAD: s_ready=1 (combinational from state). Transfer = s_valid & s_ready.
  - On transfer: mem_we<=1, mem_waddr<=count[ADDR_W-1:0], mem_wdata<=s_data, checksum<=checksum+s_data (carry discarded), count<=count+1.
  - On a transfer with count == len-1: go to DONE.
  - No transfer: mem_we<=0, all else held. Idle cycles (s_valid=0) are unbounded and legal.
- DONE: done=1, s_ready=0; next edge core_hold<=0, go to IDLE.
- mem_we is 0 in every cycle that does not follow a transfer edge.
- start outside IDLE is ignored (no effect on len, count, err, checksum).
- Addresses never wrap: the len check guarantees count < 2**ADDR_W on every write.
- checksum holds its value after DONE until the next accepted start.
- Memory contents written before a reset are not cleared; the loader has no read path.

## Timing
- Reset values: state=IDLE, s_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, core_hold=1, busy=0, done=0, err=0, checksum=0, count=0.
- The core stays held from reset until the first successful session completes.
- start accepted at edge t: in LOAD, s_ready=1 from cycle t (after edge t).
- Word transferred at edge k: mem_we/mem_waddr/mem_wdata valid during cycle k..k+1; memory commits at edge k+1 (1-cycle write latency).
- Last transfer at edge k: done=1 and busy=1 during cycle k..k+1; last memory write commits at edge k+1; core_hold=0 from edge k+1, i.e. the core is released only after the final write.
- Back-to-back transfers with s_valid held high sustain 1 word/cycle: an N-word load from start to done takes N+1 edges.
- busy = (state != IDLE). done and err are registered outputs.
- rst asserted mid-session: all outputs return to reset values immediately (asynchronous), the partial image is abandoned and core_hold=1.

## Test plan
- Reset, then start with len=2, words 0x00a00093 and 0x00100113 sent back to back -> writes at addresses 0 and 1 on consecutive cycles, done pulses once, checksum=0x00b001a6, core_hold falls the cycle after the last mem_we.
- len=4 with s_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes at addresses 0..3 in order, no mem_we in gap cycles, done after the 4th transfer.
- len=256 of 0xFFFFFFFF -> last write at address 255, checksum=0xFFFFFF00, no wrap to address 0.
- len=257 -> err=1, no writes, busy never high, core_hold unchanged; a following len=0 start -> err=0, done pulse, checksum=0, no writes.
- start pulsed during LOAD with a different len -> ignored: word count and checksum match the original len.
- rst asserted after 3 of 8 words -> core_hold=1, busy=0, mem_we=0, checksum=0 immediately; a new len=1 session then completes normally.
